// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: sequences PC loads around the one-cycle
// registered instruction memory and hands instructions to decode via valid/ready.
module fetch_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             Reset,
    output logic             PC_LdEn,
    output logic             PC_sel,
    output logic             Instr_valid,
    input  logic             Instr_ready,
    input  logic             Br_valid,
    input  logic             Br_taken,
    input  logic             Stall,
    input  logic             Halt,
    output logic             Halted,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count
);

    // Three bits leave spare encodings; any of them falls back to BOOT.
    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        VALID  = 3'd2,
        HALTED = 3'd3
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   fetch_inc;
    logic   stall_inc;
    logic   stall_sat;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = BOOT;
        PC_LdEn     = 1'b0;
        PC_sel      = 1'b0;
        Instr_valid = 1'b0;
        Halted      = 1'b0;
        accept      = 1'b0;
        fetch_inc   = 1'b0;
        stall_inc   = 1'b0;
        case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: state_nxt = VALID;
            VALID: begin
                Instr_valid = 1'b1;
                accept      = Instr_ready & ~Stall;
                if (accept) begin
                    PC_LdEn   = 1'b1;
                    PC_sel    = Br_valid & Br_taken;
                    fetch_inc = 1'b1;
                    state_nxt = Halt ? HALTED : FETCH;
                end else begin
                    stall_inc = ~stall_sat;
                    state_nxt = VALID;
                end
            end
            HALTED: begin
                Halted    = 1'b1;
                state_nxt = HALTED;
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign stall_sat = &stall_count;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fetch_inc) fetch_count <= fetch_count + 1'b1;
            if (stall_inc) stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised + directed bench for fetch_sequencer; two instances (CNT_W=16 and 4)
// share the stimulus and are checked every cycle against a gap-counting model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic Reset = 1'b0;
    logic Instr_ready = 1'b0, Br_valid = 1'b0, Br_taken = 1'b0, Stall = 1'b0, Halt = 1'b0;
    logic ld16, sel16, iv16, h16, ld4, sel4, iv4, h4;
    logic [15:0] fc16, sc16;
    logic [3:0]  fc4, sc4;
    int pc_immed = 0;

    int errors = 0, checks = 0;

    // model: cycles until an instruction is presented, halted flag, counts, fetch-stage PC
    int gap = 2;
    bit m_halted = 0;
    int m_fetch = 0, m_stall = 0, m_pc = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.CNT_W(16)) dut16 (
        .clk(clk), .Reset(Reset), .PC_LdEn(ld16), .PC_sel(sel16), .Instr_valid(iv16),
        .Instr_ready(Instr_ready), .Br_valid(Br_valid), .Br_taken(Br_taken),
        .Stall(Stall), .Halt(Halt), .Halted(h16), .fetch_count(fc16), .stall_count(sc16));

    fetch_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .Reset(Reset), .PC_LdEn(ld4), .PC_sel(sel4), .Instr_valid(iv4),
        .Instr_ready(Instr_ready), .Br_valid(Br_valid), .Br_taken(Br_taken),
        .Stall(Stall), .Halt(Halt), .Halted(h4), .fetch_count(fc4), .stall_count(sc4));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // per-cycle compare against the model, sampled mid-cycle
    initial forever begin
        bit pres, acc, e_sel;
        @(negedge clk);
        if (!Reset) begin
            pres = 0; acc = 0; e_sel = 0;
            m_fetch = 0; m_stall = 0; m_pc = 0; gap = 2; m_halted = 0;
        end else begin
            pres  = !m_halted && gap == 0;
            acc   = pres && Instr_ready && !Stall;
            e_sel = acc && Br_valid && Br_taken;
        end
        chk("ivalid16", iv16, pres);   chk("ivalid4", iv4, pres);
        chk("ldEn16", ld16, acc);      chk("ldEn4", ld4, acc);
        chk("sel16", sel16, e_sel);    chk("sel4", sel4, e_sel);
        chk("halted16", h16, Reset ? m_halted : 0);
        chk("halted4", h4, Reset ? m_halted : 0);
        chk("fcount16", fc16, m_fetch % 65536);
        chk("fcount4", fc4, m_fetch % 16);
        chk("scount16", sc16, sat(m_stall, 65535));
        chk("scount4", sc4, sat(m_stall, 15));
        if (Reset) begin
            if (pres) begin
                if (acc) begin
                    m_fetch++;
                    m_pc += 4 + (e_sel ? pc_immed : 0);
                    if (Halt) m_halted = 1;
                    else      gap = 1;
                end else m_stall++;
            end else if (!m_halted) gap--;
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // inputs set before calling; release lands just after an edge
    task automatic do_reset();
        Reset = 1'b0;
        step(2);
        Reset = 1'b1;
    endtask

    initial begin
        // reset state while held
        step(1);
        chk("rst_ivalid", iv16, 0);
        chk("rst_fc", fc16, 0);

        // 10 accepts with no stalls
        Instr_ready = 1;
        do_reset();
        for (int k = 0; k < 100 && m_fetch < 10; k++) step(1);
        chk("ten_model_fc", m_fetch, 10);
        chk("ten_dut_fc", fc16, 10);
        chk("ten_pc", m_pc, 32'h28);

        // stall 3 VALID cycles then accept
        Stall = 1;
        do_reset();
        step(5);
        chk("stall_ivalid", iv16, 1);
        chk("stall_ld", ld16, 0);
        chk("stall_cnt", sc16, 3);
        Stall = 0;
        #1 chk("stall_accept_ld", ld16, 1);
        step(1);
        chk("stall_fc", fc16, 1);
        chk("stall_pc", m_pc, 4);

        // taken branch at PC=8 with imm 0x10
        Stall = 0;
        do_reset();
        step(6);
        pc_immed = 32'h10; Br_valid = 1; Br_taken = 1;
        #1 chk("br_sel", sel16, 1);
        chk("br_ld", ld16, 1);
        step(1);
        chk("br_pc", m_pc, 32'h1C);
        Br_valid = 0; Br_taken = 0;

        // not-taken branch
        do_reset();
        step(6);
        Br_valid = 1; Br_taken = 0;
        #1 chk("nbr_sel", sel16, 0);
        step(1);
        chk("nbr_pc", m_pc, 32'hC);
        Br_valid = 0;

        // halt at accept, then toggle inputs
        do_reset();
        step(2);
        Halt = 1; Br_valid = 1; Br_taken = 1; pc_immed = 32'h20;
        step(1);
        chk("halt_h", h16, 1);
        chk("halt_pc", m_pc, 32'h24);
        Halt = 0; Br_valid = 0; Br_taken = 0;
        for (int i = 0; i < 10; i++) begin
            Instr_ready = 1'($urandom); Stall = 1'($urandom);
            step(1);
        end
        chk("halt_iv", iv16, 0);
        chk("halt_fc_frozen", fc16, 1);

        // wrap and saturation on the narrow counters
        Instr_ready = 1; Stall = 0;
        do_reset();
        for (int k = 0; k < 100 && m_fetch < 17; k++) step(1);
        chk("wrap_fc4", fc4, 1);
        chk("wrap_fc16", fc16, 17);
        Stall = 1;
        step(21);
        chk("sat_sc4", sc4, 15);
        chk("sat_sc16", sc16, 20);

        // asynchronous reset between edges while VALID
        #2 Reset = 0;
        #1 chk("async_iv", iv16, 0);
        chk("async_fc", fc16, 0);
        chk("async_sc", sc16, 0);
        step(1);
        Stall = 0;
        Reset = 1;
        step(3);
        chk("restart_pc", m_pc, 4);

        // randomised traffic
        for (int i = 0; i < 1500; i++) begin
            Instr_ready = ($urandom_range(0, 3) != 0);
            Stall       = ($urandom_range(0, 3) == 0);
            Br_valid    = 1'($urandom);
            Br_taken    = 1'($urandom);
            Halt        = ($urandom_range(0, 40) == 0);
            pc_immed    = 4 * $urandom_range(0, 255);
            Reset       = ($urandom_range(0, 60) != 0);
            step(1);
        end
        Reset = 1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
